// File: rtl/layer_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: state encoding, phase/action codes
// and stream source indices.
package layer_seq_pkg;

    // Phase states reuse their phase code so reg3 snapshots read directly as phase numbers.
    typedef enum logic [7:0] {
        ST_IDLE   = 8'h00,
        ST_BIAS   = 8'h02,
        ST_ACT    = 8'h03,
        ST_FEAT   = 8'h04,
        ST_WEIGHT = 8'h05,
        ST_CONV   = 8'h06,
        ST_RX     = 8'h07,
        ST_DONE   = 8'h08,
        ST_ERR    = 8'h0F
    } state_e;

    localparam logic [3:0] PH_BIAS   = 4'd2;
    localparam logic [3:0] PH_ACT    = 4'd3;
    localparam logic [3:0] PH_WEIGHT = 4'd5;
    localparam logic [3:0] PH_FEAT   = 4'd4;

    localparam logic [3:0] ACT_TX    = 4'd1;
    localparam logic [3:0] ACT_CONV  = 4'd4;
    localparam logic [3:0] ACT_RX    = 4'd2;
    localparam logic [3:0] ACT_NONE  = 4'd0;

    localparam int NUM_SRC    = 4;
    localparam int SRC_BIAS   = 0;
    localparam int SRC_ACT    = 1;
    localparam int SRC_WEIGHT = 2;
    localparam int SRC_FEAT   = 3;

    function automatic state_e first_phase(input logic skip_bias, input logic skip_act);
        if (!skip_bias)
            return ST_BIAS;
        else if (!skip_act)
            return ST_ACT;
        else
            return ST_WEIGHT;
    endfunction

    function automatic logic [31:0] phase_cmd(input logic [3:0] ph);
        return {24'h0, ph, ACT_TX};
    endfunction

endpackage

// File: rtl/layer_seq_axis_mux.sv
// 4:1 AXI-Stream source mux onto MM2S plus per-source ready demux; purely combinational.
module layer_seq_axis_mux
    import layer_seq_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_last,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready
);

    // Valid/ready: a beat moves on any cycle with tvalid && tready; valid must not wait
    // on ready, and data/last must hold while valid is high and ready is low.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_en[k]) begin
                m_axis_tdata  = src_data[k*DATA_W +: DATA_W];
                m_axis_tvalid = src_valid[k];
                m_axis_tlast  = src_last[k];
            end
        end
    end

    assign src_ready = src_en & {NUM_SRC{m_axis_tready}};

endmodule

// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: bias -> act LUT -> weight -> N x (feature, conv) -> read-back.
// Optional watchdog enabled by defining LAYER_SEQ_WDOG_EN.
module layer_seq_ctrl
    import layer_seq_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int BATCH_W = 16,
    parameter int WDOG_W  = 24
) (
    input  logic                  sclk,
    input  logic                  s_rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic                  cfg_skip_bias,
    input  logic                  cfg_skip_act,
    input  logic [BATCH_W-1:0]    cfg_batch_num,
    input  logic [15:0]           cfg_tx_len,
    input  logic [15:0]           cfg_conv_len,
    input  logic [15:0]           cfg_feat_cmd,
    input  logic [31:0]           cfg_shape,
    input  logic [WDOG_W-1:0]     cfg_wdog_limit,
    input  logic                  task_finish,
    input  logic [4*DATA_W-1:0]   src_data,
    input  logic [3:0]            src_valid,
    input  logic [3:0]            src_last,
    output logic [3:0]            src_ready,
    output logic [3:0]            src_en,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           reg0,
    output logic [31:0]           reg1,
    output logic [31:0]           reg2,
    output logic [31:0]           reg3,
    output logic [BATCH_W-1:0]    batch_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            state_dbg
);

    state_e               state_q, state_d;
    logic                 start_ok;
    logic                 wdog_hit;
    logic [BATCH_W-1:0]   n_eff;
    logic                 last_batch;
    logic [BATCH_W-1:0]   batch_next;
    logic [31:0]          feat_word;

    assign n_eff      = (cfg_batch_num == '0) ? BATCH_W'(1) : cfg_batch_num;
    assign last_batch = (batch_cnt == n_eff - BATCH_W'(1));
    assign start_ok   = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Batch index that the FEAT phase being entered will run with.
    assign batch_next = (state_q == ST_CONV) ? batch_cnt + BATCH_W'(1) : '0;
    assign feat_word  = {cfg_feat_cmd, 3'b010,
                         (batch_next == n_eff - BATCH_W'(2)),
                         (batch_next != '0),
                         3'b000, PH_FEAT, ACT_TX};

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign m_axis_tkeep = '1;
    assign state_dbg    = state_q;

    always_comb begin
        state_d = state_q;
        src_en  = 4'b0000;
        case (state_q)
            ST_IDLE, ST_DONE: if (cfg_start) state_d = first_phase(cfg_skip_bias, cfg_skip_act);
            ST_BIAS: begin
                src_en[SRC_BIAS] = 1'b1;
                if (task_finish) state_d = cfg_skip_act ? ST_WEIGHT : ST_ACT;
            end
            ST_ACT: begin
                src_en[SRC_ACT] = 1'b1;
                if (task_finish) state_d = ST_WEIGHT;
            end
            ST_WEIGHT: begin
                src_en[SRC_WEIGHT] = 1'b1;
                if (task_finish) state_d = ST_FEAT;
            end
            ST_FEAT: begin
                src_en[SRC_FEAT] = 1'b1;
                if (task_finish) state_d = ST_CONV;
            end
            ST_CONV: if (task_finish) state_d = last_batch ? ST_RX : ST_FEAT;
            ST_RX:   if (task_finish) state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
        if (wdog_hit)  state_d = ST_ERR;
        if (cfg_abort) state_d = ST_IDLE;
    end

    // Command registers load on phase entry; the low nibble is a one-cycle action pulse.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            reg0      <= '0;
            reg1      <= '0;
            reg2      <= '0;
            batch_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == ST_DONE) && (state_q != ST_DONE);
            if (cfg_abort) begin
                reg0      <= '0;
                batch_cnt <= '0;
            end else if (state_d != state_q) begin
                if (start_ok) begin
                    reg1      <= {cfg_tx_len, 16'h0};
                    reg2      <= cfg_shape;
                    batch_cnt <= '0;
                end
                case (state_d)
                    ST_BIAS:   reg0 <= phase_cmd(PH_BIAS);
                    ST_ACT:    reg0 <= phase_cmd(PH_ACT);
                    ST_WEIGHT: reg0 <= phase_cmd(PH_WEIGHT);
                    ST_FEAT: begin
                        reg0      <= feat_word;
                        batch_cnt <= batch_next;
                    end
                    ST_CONV: begin
                        reg0[3:0] <= ACT_CONV;
                        reg1      <= {cfg_conv_len, 16'(batch_cnt)};
                    end
                    ST_RX: begin
                        reg0[3:0] <= ACT_RX;
                        batch_cnt <= '0;
                    end
                    ST_DONE:   reg0[3:0] <= ACT_NONE;
                    default:   reg0[3:0] <= ACT_NONE;
                endcase
            end else begin
                reg0[3:0] <= ACT_NONE;
            end
        end
    end

`ifdef LAYER_SEQ_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_hit = busy && !task_finish && (cfg_wdog_limit != '0) &&
                      (wdog_cnt == cfg_wdog_limit - WDOG_W'(1));

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wdog_cnt <= '0;
            err      <= 1'b0;
            reg3     <= '0;
        end else begin
            if ((state_d != state_q) || task_finish)
                wdog_cnt <= '0;
            else if (busy)
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            // err stays set through abort; the next accepted start clears it.
            if (!cfg_abort && start_ok)
                err <= 1'b0;
            if (!cfg_abort && (state_d == ST_ERR) && (state_q != ST_ERR)) begin
                err  <= 1'b1;
                reg3 <= {8'h0, state_q, 16'(batch_cnt)};
            end
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^cfg_wdog_limit;
    assign wdog_hit    = 1'b0;
    assign err         = 1'b0;
    assign reg3        = '0;
`endif

    layer_seq_axis_mux #(.DATA_W(DATA_W)) u_axis_mux (
        .src_en        (src_en),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: command pulses and MM2S beats are checked by a
// negedge monitor against expected queues filled by the stimulus tasks.
module tb_layer_seq_ctrl;

    localparam int DATA_W  = 64;
    localparam int BATCH_W = 16;
    localparam int WDOG_W  = 24;
    localparam logic [7:0] S_IDLE   = 8'h00;
    localparam logic [7:0] S_WEIGHT = 8'h05;
    localparam logic [7:0] S_DONE   = 8'h08;
    localparam logic [7:0] S_ERR    = 8'h0F;

    logic                  sclk, s_rst_n;
    logic                  cfg_start, cfg_abort, cfg_skip_bias, cfg_skip_act;
    logic [BATCH_W-1:0]    cfg_batch_num;
    logic [15:0]           cfg_tx_len, cfg_conv_len, cfg_feat_cmd;
    logic [31:0]           cfg_shape;
    logic [WDOG_W-1:0]     cfg_wdog_limit;
    logic                  task_finish;
    logic [4*DATA_W-1:0]   src_data;
    logic [3:0]            src_valid, src_last, src_ready, src_en;
    logic [DATA_W-1:0]     m_axis_tdata;
    logic [DATA_W/8-1:0]   m_axis_tkeep;
    logic                  m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]           reg0, reg1, reg2, reg3;
    logic [BATCH_W-1:0]    batch_cnt;
    logic                  busy, done, err;
    logic [7:0]            state_dbg;

    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;
    int   stray_ready = 0;
    logic in_feat = 1'b0;
    logic stream_on = 1'b0;

    logic [63:0]       exp_q[$];
    logic [DATA_W:0]   exp_beat_q[$];
    logic [DATA_W-1:0] feat_beats [5];

    layer_seq_ctrl #(.DATA_W(DATA_W), .BATCH_W(BATCH_W), .WDOG_W(WDOG_W)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_skip_bias(cfg_skip_bias), .cfg_skip_act(cfg_skip_act),
        .cfg_batch_num(cfg_batch_num), .cfg_tx_len(cfg_tx_len),
        .cfg_conv_len(cfg_conv_len), .cfg_feat_cmd(cfg_feat_cmd),
        .cfg_shape(cfg_shape), .cfg_wdog_limit(cfg_wdog_limit),
        .task_finish(task_finish),
        .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
        .src_ready(src_ready), .src_en(src_en),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .batch_cnt(batch_cnt), .busy(busy), .done(done), .err(err),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // MM2S ready: toggles every cycle while a stream test runs, otherwise held high.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge sclk);
            #1;
            m_axis_tready = stream_on ? ~m_axis_tready : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge sclk) begin : monitor
        logic [63:0]     e;
        logic [DATA_W:0] eb;
        if (s_rst_n) begin
            if (reg0[3:0] != 4'h0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL cmd_unexpected: got reg1_reg0 %h_%h, expected no command", reg1, reg0);
                end else begin
                    e = exp_q.pop_front();
                    if ({reg1, reg0} !== e) begin
                        fails++;
                        $display("FAIL cmd: got reg1_reg0 %h_%h, expected %h_%h", reg1, reg0, e[63:32], e[31:0]);
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                tests++;
                if (exp_beat_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got last %b data %h, expected no beat", m_axis_tlast, m_axis_tdata);
                end else begin
                    eb = exp_beat_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== eb) begin
                        fails++;
                        $display("FAIL beat: got last %b data %h, expected last %b data %h",
                                 m_axis_tlast, m_axis_tdata, eb[DATA_W], eb[DATA_W-1:0]);
                    end
                end
            end
            if (done) done_seen++;
            if (in_feat && (src_ready[2:0] != 3'b000)) stray_ready++;
        end
    end

    // Driver tasks
    task automatic pulse(input logic st, input logic fin, input logic ab);
        @(posedge sclk);
        #1;
        cfg_start = st; task_finish = fin; cfg_abort = ab;
        @(posedge sclk);
        #1;
        cfg_start = 1'b0; task_finish = 1'b0; cfg_abort = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [31:0] r1, input logic [31:0] r0);
        exp_q.push_back({r1, r0});
        pulse(st, !st, 1'b0);
    endtask

    task automatic configure(input logic [BATCH_W-1:0] n, input logic sb, input logic sa,
                             input logic [15:0] tx, input logic [15:0] cv,
                             input logic [15:0] fc, input logic [31:0] sh);
        cfg_batch_num = n; cfg_skip_bias = sb; cfg_skip_act = sa;
        cfg_tx_len = tx; cfg_conv_len = cv; cfg_feat_cmd = fc; cfg_shape = sh;
    endtask

    task automatic send_feat_beats(input int n);
        logic hs;
        for (int i = 0; i < n; i++) begin
            exp_beat_q.push_back({(i == n - 1), feat_beats[i]});
            @(posedge sclk);
            #1;
            src_data[3*DATA_W +: DATA_W] = feat_beats[i];
            src_valid[3] = 1'b1;
            src_last[3]  = (i == n - 1);
            hs = 1'b0;
            for (int c = 0; c < 20 && !hs; c++) begin
                @(negedge sclk);
                if (src_ready[3]) hs = 1'b1;
            end
            check("feat_beat_handshake", {63'h0, hs}, 64'h1);
        end
        @(posedge sclk);
        #1;
        src_valid[3] = 1'b0;
        src_last[3]  = 1'b0;
    endtask

    initial begin
        feat_beats[0] = 64'hFEED_0000_0000_0001;
        feat_beats[1] = 64'hFEED_0000_0000_0002;
        feat_beats[2] = 64'hFEED_0000_0000_0003;
        feat_beats[3] = 64'hFEED_0000_0000_0004;
        feat_beats[4] = 64'hFEED_0000_0000_0005;
        s_rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0; task_finish = 1'b0;
        configure(16'd3, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'hABCD, 32'h1234_5678);
        cfg_wdog_limit = 24'd100;
        src_data = '0; src_valid = 4'h0; src_last = 4'h0;
        repeat (3) @(posedge sclk);
        #1;
        s_rst_n = 1'b1;

        // Reset state
        check("rst_state", {56'h0, state_dbg}, {56'h0, S_IDLE});
        check("rst_reg0", {32'h0, reg0}, 64'h0);
        check("rst_reg1", {32'h0, reg1}, 64'h0);
        check("rst_reg2", {32'h0, reg2}, 64'h0);
        check("rst_reg3", {32'h0, reg3}, 64'h0);
        check("rst_flags", {48'h0, batch_cnt, busy, done, err, src_en, m_axis_tvalid}, 64'h0);
        check("tkeep", {56'h0, m_axis_tkeep}, 64'hFF);

        // N=3, no skips
        issue(1'b1, 32'h0010_0000, 32'h0000_0021);
        check("t1_reg2", {32'h0, reg2}, 64'h1234_5678);
        check("t1_busy", {63'h0, busy}, 64'h1);
        issue(1'b0, 32'h0010_0000, 32'h0000_0031);
        issue(1'b0, 32'h0010_0000, 32'h0000_0051);
        issue(1'b0, 32'h0010_0000, 32'hABCD_4041);
        issue(1'b0, 32'h0020_0000, 32'hABCD_4044);
        issue(1'b0, 32'h0020_0000, 32'hABCD_5841);
        issue(1'b0, 32'h0020_0001, 32'hABCD_5844);
        issue(1'b0, 32'h0020_0001, 32'hABCD_4841);
        issue(1'b0, 32'h0020_0002, 32'hABCD_4844);
        issue(1'b0, 32'h0020_0002, 32'hABCD_4842);
        pulse(1'b0, 1'b1, 1'b0);
        check("t1_done_state", {56'h0, state_dbg}, {56'h0, S_DONE});
        check("t1_done_pulse", {63'h0, done}, 64'h1);
        check("t1_reg0_done", {32'h0, reg0}, 64'hABCD_4840);
        check("t1_idle_flags", {47'h0, batch_cnt, busy}, 64'h0);
        @(posedge sclk);
        #1;
        check("t1_done_1cyc", {63'h0, done}, 64'h0);

        // N=4, skip bias, started from DONE
        configure(16'd4, 1'b1, 1'b0, 16'h0008, 16'h0009, 16'h1111, 32'hCAFE_0004);
        issue(1'b1, 32'h0008_0000, 32'h0000_0031);
        issue(1'b0, 32'h0008_0000, 32'h0000_0051);
        issue(1'b0, 32'h0008_0000, 32'h1111_4041);
        issue(1'b0, 32'h0009_0000, 32'h1111_4044);
        issue(1'b0, 32'h0009_0000, 32'h1111_4841);
        issue(1'b0, 32'h0009_0001, 32'h1111_4844);
        issue(1'b0, 32'h0009_0001, 32'h1111_5841);
        issue(1'b0, 32'h0009_0002, 32'h1111_5844);
        issue(1'b0, 32'h0009_0002, 32'h1111_4841);
        issue(1'b0, 32'h0009_0003, 32'h1111_4844);
        issue(1'b0, 32'h0009_0003, 32'h1111_4842);
        pulse(1'b0, 1'b1, 1'b0);
        check("t2_done_pulse", {63'h0, done}, 64'h1);
        check("t2_reg2", {32'h0, reg2}, 64'hCAFE_0004);

        // Skip bias+act, batch_num 0 behaves as 1
        configure(16'd0, 1'b1, 1'b1, 16'h0004, 16'h0005, 16'h00FF, 32'h0);
        issue(1'b1, 32'h0004_0000, 32'h0000_0051);
        issue(1'b0, 32'h0004_0000, 32'h00FF_4041);
        issue(1'b0, 32'h0005_0000, 32'h00FF_4044);
        issue(1'b0, 32'h0005_0000, 32'h00FF_4042);
        pulse(1'b0, 1'b1, 1'b0);
        check("t3_done_pulse", {63'h0, done}, 64'h1);
        pulse(1'b0, 1'b1, 1'b0);
        check("t3_finish_in_done", {56'h0, state_dbg}, {56'h0, S_DONE});
        check("t3_no_redone", {63'h0, done}, 64'h0);

        // Feature stream with toggling ready, then abort with finish in CONV
        configure(16'd2, 1'b1, 1'b1, 16'h0003, 16'h0007, 16'h2222, 32'h0);
        issue(1'b1, 32'h0003_0000, 32'h0000_0051);
        issue(1'b0, 32'h0003_0000, 32'h2222_5041);
        check("t4_src_en_feat", {60'h0, src_en}, 64'h8);
        src_data[3*DATA_W-1:0] = {3{64'hDEAD_BEEF_DEAD_BEEF}};
        src_valid[2:0] = 3'b111;
        src_last[2:0]  = 3'b111;
        in_feat = 1'b1;
        stream_on = 1'b1;
        send_feat_beats(5);
        stream_on = 1'b0;
        in_feat = 1'b0;
        src_valid = 4'h0;
        src_last  = 4'h0;
        check("t4_stray_ready", stray_ready, 0);
        issue(1'b0, 32'h0007_0000, 32'h2222_5044);
        src_valid = 4'hF;
        src_last  = 4'hF;
        #1;
        check("t4_conv_stream_idle", {m_axis_tdata[62:0], m_axis_tvalid}, 64'h0);
        check("t4_conv_tlast", {59'h0, m_axis_tlast, src_ready}, 64'h0);
        src_valid = 4'h0;
        src_last  = 4'h0;
        issue(1'b0, 32'h0007_0000, 32'h2222_4841);
        issue(1'b0, 32'h0007_0001, 32'h2222_4844);
        check("t4_batch1", {48'h0, batch_cnt}, 64'h1);
        pulse(1'b0, 1'b1, 1'b1);
        check("t4_abort_state", {56'h0, state_dbg}, {56'h0, S_IDLE});
        check("t4_abort_reg0", {32'h0, reg0}, 64'h0);
        check("t4_abort_flags", {43'h0, batch_cnt, src_en, busy}, 64'h0);

        // Watchdog: no finish while in WEIGHT
        configure(16'd1, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'h3333, 32'h0);
        issue(1'b1, 32'h0001_0000, 32'h0000_0021);
        issue(1'b0, 32'h0001_0000, 32'h0000_0031);
        issue(1'b0, 32'h0001_0000, 32'h0000_0051);
`ifdef LAYER_SEQ_WDOG_EN
        begin
            int cyc = 0;
            for (int k = 1; k <= 200 && cyc == 0; k++) begin
                @(posedge sclk);
                #1;
                if (state_dbg == S_ERR) cyc = k;
            end
            check("wdog_cycles", cyc, 100);
        end
        check("wdog_err", {63'h0, err}, 64'h1);
        check("wdog_reg3", {32'h0, reg3}, 64'h0005_0000);
        check("wdog_outputs", {59'h0, src_en, busy}, 64'h0);
        pulse(1'b0, 1'b1, 1'b0);
        check("wdog_finish_in_err", {56'h0, state_dbg}, {56'h0, S_ERR});
`else
        repeat (150) @(posedge sclk);
        #1;
        check("nowdog_state", {56'h0, state_dbg}, {56'h0, S_WEIGHT});
        check("nowdog_err_reg3", {31'h0, err, reg3}, 64'h0);
        check("nowdog_busy", {63'h0, busy}, 64'h1);
`endif
        pulse(1'b0, 1'b0, 1'b1);
        check("final_abort_state", {56'h0, state_dbg}, {56'h0, S_IDLE});

        repeat (3) @(posedge sclk);
        #1;
        check("cmd_queue_empty", exp_q.size(), 0);
        check("beat_queue_empty", exp_beat_q.size(), 0);
        check("done_count", done_seen, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
